seg_decode: RTL and testbench
=============================

# seg_decode

Seven-segment pattern decoder. It is the receive-side counterpart of the board's BCD-to-segment encoder. It samples an active-low 7-bit segment bus, filters transient patterns, and maps each stable pattern back to its 4-bit code. Each decoded code is delivered through a one-entry valid/ready holding register. It sits on the system bus as a display loopback/readback monitor, letting a master confirm what a display port is actually driving.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 1–255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `hex_in`  in  7  segment bus, active-low, bit 6 = segment g … bit 0 = segment a; asynchronous to `clk`.
- `bcd_out`  out  4  decoded code; valid while `out_valid`=1.
- `out_valid`  out  1  holding register contains an unconsumed code.
- `out_ready`  in  1  consumer accepts `bcd_out` when `out_valid` and `out_ready` are both 1 at a rising edge.
- `code_err`  out  1  sticky: the last accepted pattern was not in the code set.
- `overrun`  out  1  sticky: an unconsumed code was overwritten.

## Operation
- Code set, `hex_in` to `bcd_out`:
  - 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3, 0011001 = 4
  - 0010010 = 5, 0000010 = 6, 1111000 = 7, 0000000 = 8, 0010000 = 9
  - 0111101 = 10, 0111011 = 11, 0111111 = 12
  - Any other pattern is invalid.
- Sample path `s`: `hex_in` after the optional synchroniser (see Configuration).
- Registers:
  - `cand` (7 bits): candidate pattern.
  - `cnt` (8 bits): stability counter.
  - `last` (7 bits): last accepted pattern.
  - Output holding register.
- FSM states: IDLE, SETTLE.
  - IDLE: if `s` != `last`, load `cand`=`s`, `cnt`=1, and go to SETTLE; otherwise stay.
  - SETTLE, `s` != `cand`: reload `cand`=`s`, `cnt`=1, stay in SETTLE (restart filter).
  - SETTLE, `s` == `cand` and `cnt` < `STABLE_CYCLES`: `cnt`++.
  - SETTLE, `cnt` == `STABLE_CYCLES`: accept, set `last`=`cand`, go to IDLE.
    - If `cand` == `last` at acceptance (glitch returned to the old pattern): no emit.
  - `STABLE_CYCLES`=1: acceptance occurs on the edge after entering SETTLE.
- On acceptance:
  - Valid code: `bcd_out` <= code, `out_valid` <= 1, `code_err` <= 0.
  - Invalid pattern: `code_err` <= 1; `bcd_out` and `out_valid` unchanged.
  - Storing the invalid pattern in `last` prevents repeated errors while it is held.
- Handshake:
  - `out_valid` stays high until an edge with `out_ready`=1, then clears.
  - `bcd_out` is stable while `out_valid`=1, except on overwrite.
- Simultaneous events:
  - Acceptance of a valid code with `out_valid`=1 and `out_ready`=0: overwrite `bcd_out`, keep `out_valid`=1, set `overrun`.
  - Acceptance with `out_valid`=1 and `out_ready`=1 on the same edge: old code consumed, new code loaded, `out_valid` stays 1, no overrun.
- Sticky flags:
  - `code_err` clears only on reset or on acceptance of a valid code.
  - `overrun` clears only on reset.
- Reset (asynchronous, any time, including mid-SETTLE):
  - State IDLE, `cand`=`last`=1111111 (blank), `cnt`=0, synchroniser flops = 1111111.
  - `bcd_out`=0, `out_valid`=0, `code_err`=0, `overrun`=0.
  - Any pending code is discarded.

## Timing
- Sync compiled in: a new pattern set up before edge E0 and held reaches `s` after edge E1.
  - SETTLE is entered at E2; acceptance happens at E(2+`STABLE_CYCLES`).
  - `out_valid` is high in the cycle after E(2+`STABLE_CYCLES`): after E6 for the default.
- Sync compiled out: `s` = `hex_in`, so every event above occurs two edges earlier.
- Minimum spacing between two emitted codes: `STABLE_CYCLES`+1 edges.
- Single-cycle `hex_in` glitch (default parameters): never emitted; restarts or aborts the filter only.
- `out_ready` has no combinational path to any output; all outputs are registered.

## Configuration
- `SEG_DECODE_SYNC_EN` defined: two-flop synchroniser on all 7 `hex_in` bits; latency as in Timing.
- `SEG_DECODE_SYNC_EN` undefined: no synchroniser; `hex_in` must be synchronous to `clk`; latency reduced by two cycles.

## Test plan
- Reset, hold `out_ready`=1, drive 0100100 (sync on) → `out_valid` pulses 1 cycle after E6 with `bcd_out`=2; `code_err`=0.
- Drive 0000010 with `out_ready`=0 for 20 cycles → `out_valid`=1, `bcd_out`=6 held constant, exactly one code emitted.
- From accepted 1111001, pulse 0000000 for 2 cycles, then return to 1111001 → no new `out_valid`; `bcd_out` unchanged.
- Drive 1010101 → `code_err`=1, `out_valid` unchanged; then drive 0111111 → `bcd_out`=12, `code_err`=0.
- With `out_ready`=0, accept 3 (0110000) then 9 (0010000) → `bcd_out`=9, `overrun`=1. Repeat with `out_ready`=1 on the acceptance edge of 9 → `overrun` stays 0.
- Assert `rstn`=0 mid-SETTLE while `out_valid`=1 → all outputs are 0 immediately (asynchronously); after release, a held 1000000 emits `bcd_out`=0.

Source files
------------

// File: rtl/seg_decode_if.sv
// Segment readback bus: the raw segment pattern in, decoded code out through a valid/ready holding register.
// Latency: none (wiring only).
// Backpressure: out_ready from the consumer qualifies out_valid from the decoder.
interface seg_decode_if;
    logic [6:0] hex_in;
    logic [3:0] bcd_out;
    logic       out_valid;
    logic       out_ready;
    logic       code_err;
    logic       overrun;

    // Side that drives the display pattern and consumes decoded codes.
    modport master (
        output hex_in,
        output out_ready,
        input  bcd_out,
        input  out_valid,
        input  code_err,
        input  overrun
    );

    // Decoder side.
    modport slave (
        input  hex_in,
        input  out_ready,
        output bcd_out,
        output out_valid,
        output code_err,
        output overrun
    );
endinterface

// File: rtl/seg_decode.sv
// Seven-segment readback decoder: debounces an active-low segment bus and maps stable patterns to 4-bit codes.
// Latency: STABLE_CYCLES+1 edges from pattern to out_valid (plus 2 when SEG_DECODE_SYNC_EN adds the synchroniser).
// Backpressure: one-entry holding register; a new code overwrites an unconsumed one and sets sticky overrun.
module seg_decode #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rstn,
    seg_decode_if.slave  bus
);

    localparam logic [6:0] BLANK      = 7'b1111111;
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] s;
    logic [6:0] cand, cand_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [6:0] last, last_nxt;
    logic       accept;
    logic       emit;
    logic [3:0] code_val;
    logic       code_ok;

    logic [3:0] bcd_q;
    logic       valid_q;
    logic       err_q;
    logic       ovr_q;

`ifdef SEG_DECODE_SYNC_EN
    logic [6:0] sync1, sync2;

    // Two-flop synchroniser; resets to blank so a reset never looks like a new pattern.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= BLANK;
            sync2 <= BLANK;
        end else begin
            sync1 <= bus.hex_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = bus.hex_in;
`endif

    // Filter state and pattern registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cand  <= BLANK;
            cnt   <= 8'd0;
            last  <= BLANK;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: watch for a change from the last accepted pattern, then require it to hold.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        last_nxt  = last;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (s != last) begin
                    cand_nxt  = s;
                    cnt_nxt   = 8'd1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == STABLE_CNT) begin
                    accept    = 1'b1;
                    last_nxt  = cand;
                    state_nxt = IDLE;
                end else if (s != cand) begin
                    cand_nxt = s;
                    cnt_nxt  = 8'd1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pattern that settles back to the previous one was only a glitch.
    assign emit = accept && (cand != last);

    // Pattern-to-code table for the candidate being accepted.
    always_comb begin
        code_val = 4'd0;
        code_ok  = 1'b1;
        case (cand)
            7'b1000000: code_val = 4'd0;
            7'b1111001: code_val = 4'd1;
            7'b0100100: code_val = 4'd2;
            7'b0110000: code_val = 4'd3;
            7'b0011001: code_val = 4'd4;
            7'b0010010: code_val = 4'd5;
            7'b0000010: code_val = 4'd6;
            7'b1111000: code_val = 4'd7;
            7'b0000000: code_val = 4'd8;
            7'b0010000: code_val = 4'd9;
            7'b0111101: code_val = 4'd10;
            7'b0111011: code_val = 4'd11;
            7'b0111111: code_val = 4'd12;
            default:    code_ok  = 1'b0;
        endcase
    end

    // Holding register and sticky flags; a load on the consume edge wins over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcd_q   <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (emit) begin
                if (code_ok) begin
                    bcd_q   <= code_val;
                    valid_q <= 1'b1;
                    err_q   <= 1'b0;
                    if (valid_q && !bus.out_ready) begin
                        ovr_q <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.out_valid = valid_q;
    assign bus.code_err  = err_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_seg_decode.sv
// Directed bench for seg_decode: reset, decode, hold, glitch rejection, error flag, overrun, async reset.
// Latency: expectations follow STABLE_CYCLES and whether SEG_DECODE_SYNC_EN is defined.
// Backpressure: out_ready driven per scenario to exercise hold, consume and overwrite.
module tb_seg_decode;

    localparam int N = 4;
`ifdef SEG_DECODE_SYNC_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N;
`endif

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    seg_decode_if bus ();

    seg_decode #(.STABLE_CYCLES(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Change hex_in just after a rising edge; the following edge is E0.
    task automatic drive(input logic [6:0] pat);
        @(posedge clk);
        #1 bus.hex_in = pat;
    endtask

    // Advance one edge and land on the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.hex_in = 7'b1111111;
        rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.hex_in = 7'b1111111;
        bus.out_ready = 1'b0;
        #3;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bcd_out !== 4'd0 || bus.code_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b bcd=%0d err=%b ovr=%b, required all 0",
                     bus.out_valid, bus.bcd_out, bus.code_err, bus.overrun);
        end
        #10 rstn = 1'b1;
    endtask

    task automatic test_decode_pulse();
        bus.out_ready = 1'b1;
        drive(7'b0100100);
        repeat (LAT) step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_early: out_valid=%b, required 0 before acceptance", bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd2 || bus.code_err !== 1'b0) begin
            errors++;
            $display("FAIL decode_two: valid=%b bcd=%0d err=%b, required 1/2/0",
                     bus.out_valid, bus.bcd_out, bus.code_err);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bcd_out !== 4'd2) begin
            errors++;
            $display("FAIL decode_consumed: valid=%b bcd=%0d, required 0/2", bus.out_valid, bus.bcd_out);
        end
    endtask

    task automatic test_hold();
        int unstable;
        unstable = 0;
        bus.out_ready = 1'b0;
        drive(7'b0000010);
        repeat (LAT + 1) step();
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd6) unstable++;
            step();
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d cycles without valid=1/bcd=6, required 0", unstable);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_emit: overrun=%b, required 0", bus.overrun);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_consume: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        bus.out_ready = 1'b1;
        drive(7'b1111001);
        repeat (LAT + 1) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd1) begin
            errors++;
            $display("FAIL glitch_setup: valid=%b bcd=%0d, required 1/1", bus.out_valid, bus.bcd_out);
        end
        step();
        drive(7'b0000000);
        drive(7'b0000000);
        drive(7'b1111001);
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || bus.bcd_out !== 4'd1) begin
            errors++;
            $display("FAIL glitch_reject: valid seen %0d cycles, bcd=%0d, required 0 cycles, bcd=1",
                     seen, bus.bcd_out);
        end
    endtask

    task automatic test_code_err();
        bus.out_ready = 1'b1;
        drive(7'b1010101);
        repeat (LAT + 1) step();
        checks++;
        if (bus.code_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.bcd_out !== 4'd1) begin
            errors++;
            $display("FAIL err_set: err=%b valid=%b bcd=%0d, required 1/0/1",
                     bus.code_err, bus.out_valid, bus.bcd_out);
        end
        drive(7'b0111111);
        repeat (LAT) step();
        checks++;
        if (bus.code_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1 before next acceptance", bus.code_err);
        end
        step();
        checks++;
        if (bus.bcd_out !== 4'd12 || bus.code_err !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: bcd=%0d err=%b valid=%b, required 12/0/1",
                     bus.bcd_out, bus.code_err, bus.out_valid);
        end
        step();
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        drive(7'b0110000);
        repeat (LAT + 1) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd3) begin
            errors++;
            $display("FAIL ovr_first: valid=%b bcd=%0d, required 1/3", bus.out_valid, bus.bcd_out);
        end
        drive(7'b0010000);
        repeat (LAT + 1) step();
        checks++;
        if (bus.bcd_out !== 4'd9 || bus.overrun !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: bcd=%0d ovr=%b valid=%b, required 9/1/1",
                     bus.bcd_out, bus.overrun, bus.out_valid);
        end
        do_reset();
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_reset: overrun=%b, required 0", bus.overrun);
        end
        drive(7'b0110000);
        repeat (LAT + 1) step();
        drive(7'b0010000);
        repeat (LAT) step();
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.bcd_out !== 4'd9 || bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_same_edge: bcd=%0d ovr=%b valid=%b, required 9/0/1",
                     bus.bcd_out, bus.overrun, bus.out_valid);
        end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(7'b1111001);
        repeat (LAT + 1) step();
        drive(7'b0011001);
        step();
        step();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bcd_out !== 4'd0 || bus.code_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b bcd=%0d err=%b ovr=%b, required all 0",
                     bus.out_valid, bus.bcd_out, bus.code_err, bus.overrun);
        end
        bus.hex_in = 7'b1000000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (LAT + 1) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_zero: valid=%b bcd=%0d, required 1/0", bus.out_valid, bus.bcd_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_decode_pulse();
        test_hold();
        test_glitch();
        test_code_err();
        test_overrun();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
